adder_rr_arbiter: RTL and testbench
===================================

Name: adder_rr_arbiter

Overview:
- Shares one `adder` datapath instance between NREQ independent requesters.
- Arbitrates round-robin, latches the winner's operands, sequences one add, and returns the sum tagged with the requester id over a valid/ready response channel.
- Sits between requester blocks and the shared arithmetic resource; no requester touches the adder directly.

Parameters:
- NREQ, 4, number of requesters; legal range 2..16.
- WIDTH, 8, operand and sum width; passed to the adder instance.
- IDW, $clog2(NREQ), requester-id width; localparam, not overridable.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  NREQ  per-requester request valid.
- req_a  input  NREQ*WIDTH  operand A; requester i owns bits [i*WIDTH +: WIDTH].
- req_b  input  NREQ*WIDTH  operand B; same packing as req_a.
- req_ready  output  NREQ  one-hot grant/accept; at most one bit high.
- resp_valid  output  1  result available.
- resp_ready  input  1  consumer accepts result.
- resp_sum  output  WIDTH  (a+b) mod 2^WIDTH.
- resp_id  output  IDW  index of the requester that owns resp_sum.
- busy  output  1  high in any state other than IDLE.
- ops_count  output  16  completed-operation counter.

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values: all outputs 0, state=IDLE, last_grant=NREQ-1 (so the first grant goes to requester 0), operand registers 0.
- FSM has three states: IDLE, EXEC, RESP.
- IDLE, no request: stays in IDLE when req_valid==0.
- IDLE, arbitration: otherwise selects g = first i with req_valid[i]=1, searching from (last_grant+1) mod NREQ upward with wrap.
- IDLE, grant: req_ready[g]=1 combinationally in that same cycle; the handshake completes there.
- IDLE, capture: on the clock edge the block latches a_reg, b_reg and id_reg=g, sets last_grant=g, and moves to EXEC.
- EXEC: the adder sees a_reg/b_reg; its sum is registered into resp_sum and id_reg into resp_id; resp_valid<=1; state moves to RESP.
- RESP: holds resp_valid, resp_sum and resp_id stable until resp_valid&&resp_ready.
- RESP, completion: on that edge resp_valid<=0, ops_count<=ops_count+1 (wraps at 0xFFFF), state moves to IDLE.
- req_ready: 0 in EXEC and RESP. It may depend combinationally on req_valid; requesters must not make req_valid depend on req_ready.
- Requester obligation: hold req_valid/req_a/req_b stable until its req_ready is seen high.
- Latency: grant accepted in cycle T gives resp_valid high in cycle T+2 (first visible after edge T+1).
- Throughput: at most one operation per 3 cycles; no overlap of operations.
- Arithmetic: no carry-out; overflow wraps silently.
- Fairness: a continuously requesting requester waits at most NREQ-1 other grants.
- Requests arriving in EXEC/RESP: not accepted; arbitration is re-evaluated in IDLE.
- Requester dropping req_valid before grant: legal; it is simply not granted.
- Response handshake while all req_valid high: the return to IDLE costs one cycle; the next grant happens in IDLE, not in RESP.
- Reset mid-operation: state and outputs clear immediately (asynchronous). The in-flight operation is discarded with no response, and the next grant after release goes to requester 0.
- Illegal NREQ (outside 2..16): caught by an elaboration-time check.

Decomposition:
- Shared package/include adder_arb_pkg holds:
  - state encodings ST_IDLE=2'd0, ST_EXEC=2'd1, ST_RESP=2'd2;
  - the ops_count width constant 16.
- Sub-module: instantiates the existing `adder` (WIDTH passed through) as the datapath.
- Round-robin selection as a function or inline logic; no separate module.

Test Plan (NREQ=4, WIDTH=8):
- Reset: hold rst_n=0 for 3 cycles, release -> resp_valid=0, req_ready=4'b0000, busy=0, ops_count=0.
- Single request: req_valid=4'b0001, a0=8'h12, b0=8'h34 at cycle T, resp_ready=1 -> req_ready=4'b0001 at T; resp_valid=1 at T+2 with resp_sum=8'h46, resp_id=0; ops_count=1 after the handshake.
- Wrap: a1=8'hF0, b1=8'h20 on requester 1 -> resp_sum=8'h10, resp_id=1.
- Round-robin: req_valid=4'b1111 held continuously, resp_ready=1 -> grants in order 0,1,2,3,0; exactly one resp_valid every 3 cycles; ops_count=5 after 5 responses.
- Backpressure: resp_ready=0 for 5 cycles during RESP -> resp_valid, resp_sum and resp_id remain stable, req_ready=0; resp_ready=1 gives exactly one handshake, then the next grant one cycle later.
- Reset mid-operation: drive rst_n=0 while in EXEC -> resp_valid=0 and busy=0 immediately, with no response emitted. After release with req_valid=4'b1010, the first grant goes to requester 1.

Source files
------------

// File: rtl/adder_arb_pkg.sv
// adder_arb_pkg: shared state encodings and counter width for adder_rr_arbiter
package adder_arb_pkg;
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;
   localparam int OPS_W = 16;
endpackage

// File: rtl/adder.sv
// adder: shared datapath, modular WIDTH-bit sum with no carry-out
module adder #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] sum
);
   assign sum = a + b;
endmodule

// File: rtl/adder_rr_arbiter.sv
// adder_rr_arbiter: round-robin sharing of one adder between NREQ requesters
module adder_rr_arbiter
   import adder_arb_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8,
   localparam int IDW  = $clog2(NREQ)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NREQ-1:0]       req_valid,
   input  logic [NREQ*WIDTH-1:0] req_a,
   input  logic [NREQ*WIDTH-1:0] req_b,
   output logic [NREQ-1:0]       req_ready,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [WIDTH-1:0]      resp_sum,
   output logic [IDW-1:0]        resp_id,
   output logic                  busy,
   output logic [OPS_W-1:0]      ops_count
);
   if (NREQ < 2 || NREQ > 16) begin : g_bad_nreq
      $error("adder_rr_arbiter: NREQ must be within 2..16");
   end

   state_t           state, state_nxt;
   logic [IDW-1:0]   last_grant, grant, id_reg;
   logic             found;
   logic [WIDTH-1:0] a_reg, b_reg, sum;

   function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] last, input int k);
      return IDW'((int'(last) + k) % NREQ);
   endfunction

   // search starts just past the previous winner so each requester gets its turn
   always_comb begin
      found = 1'b0;
      grant = '0;
      for (int k = 1; k <= NREQ; k++) begin
         if (!found && req_valid[rr_idx(last_grant, k)]) begin
            found = 1'b1;
            grant = rr_idx(last_grant, k);
         end
      end
   end

   always_comb begin
      state_nxt = state;
      if (state == ST_IDLE && found) state_nxt = ST_EXEC;
      if (state == ST_EXEC) state_nxt = ST_RESP;
      if (state == ST_RESP && resp_ready) state_nxt = ST_IDLE;
   end

   assign req_ready = (state == ST_IDLE && found) ? NREQ'(1) << grant : '0;
   assign busy      = state != ST_IDLE;

   adder #(.WIDTH(WIDTH)) u_adder (.a(a_reg), .b(b_reg), .sum(sum));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         last_grant <= IDW'(NREQ - 1);
         id_reg     <= '0;
         a_reg      <= '0;
         b_reg      <= '0;
         resp_valid <= 1'b0;
         resp_sum   <= '0;
         resp_id    <= '0;
         ops_count  <= '0;
      end else begin
         state <= state_nxt;
         if (state == ST_IDLE && found) begin
            a_reg      <= req_a[grant*WIDTH +: WIDTH];
            b_reg      <= req_b[grant*WIDTH +: WIDTH];
            id_reg     <= grant;
            last_grant <= grant;
         end
         if (state == ST_EXEC) begin
            resp_sum   <= sum;
            resp_id    <= id_reg;
            resp_valid <= 1'b1;
         end
         if (state == ST_RESP && resp_ready) begin
            resp_valid <= 1'b0;
            ops_count  <= ops_count + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_adder_rr_arbiter.sv
// tb_adder_rr_arbiter: directed and randomized checks against a rotating-priority model
module tb_adder_rr_arbiter;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  req_valid;
   logic [31:0] req_a, req_b;
   logic [3:0]  req_ready;
   logic        resp_valid, resp_ready;
   logic [7:0]  resp_sum;
   logic [1:0]  resp_id;
   logic        busy;
   logic [15:0] ops_count;

   int tests = 0;
   int fails = 0;
   int last_g = 3;
   int ops_m = 0;
   int a_m[4];
   int b_m[4];

   adder_rr_arbiter #(.NREQ(4), .WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
      .req_ready(req_ready), .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_sum(resp_sum), .resp_id(resp_id), .busy(busy), .ops_count(ops_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // priority order is the ring of requesters starting just after the last winner
   function automatic int winner(input logic [3:0] v, input int last);
      int order[$];
      for (int k = 1; k <= 4; k++) order.push_back((last + k) % 4);
      foreach (order[i]) if (v[order[i]]) return order[i];
      return -1;
   endfunction

   task automatic do_op(input logic [3:0] v, input int hold);
      int g;
      logic [7:0] es;
      g = winner(v, last_g);
      for (int i = 0; i < 4; i++) begin
         req_a[i*8 +: 8] = 8'(a_m[i]);
         req_b[i*8 +: 8] = 8'(b_m[i]);
      end
      req_valid  = v;
      resp_ready = (hold == 0);
      #1;
      chk("grant", 32'(req_ready), 32'(1 << g));
      chk("idle_busy", 32'(busy), 0);
      es = 8'((a_m[g] + b_m[g]) % 256);
      last_g = g;
      cyc();
      chk("exec_ready", 32'(req_ready), 0);
      chk("exec_busy", 32'(busy), 1);
      chk("exec_valid", 32'(resp_valid), 0);
      a_m[g] = $urandom_range(0, 255);
      b_m[g] = $urandom_range(0, 255);
      cyc();
      chk("resp_valid", 32'(resp_valid), 1);
      chk("resp_sum", 32'(resp_sum), 32'(es));
      chk("resp_id", 32'(resp_id), 32'(g));
      chk("resp_req_ready", 32'(req_ready), 0);
      for (int i = 0; i < hold; i++) begin
         cyc();
         chk("bp_valid", 32'(resp_valid), 1);
         chk("bp_sum", 32'(resp_sum), 32'(es));
         chk("bp_id", 32'(resp_id), 32'(g));
         chk("bp_req_ready", 32'(req_ready), 0);
      end
      resp_ready = 1'b1;
      cyc();
      ops_m = (ops_m + 1) % 65536;
      chk("done_valid", 32'(resp_valid), 0);
      chk("done_busy", 32'(busy), 0);
      chk("ops_count", 32'(ops_count), 32'(ops_m));
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (3) cyc();
      rst_n = 1'b1;
      last_g = 3;
      ops_m = 0;
      #1;
   endtask

   initial begin
      req_valid  = '0;
      req_a      = '0;
      req_b      = '0;
      resp_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         a_m[i] = $urandom_range(0, 255);
         b_m[i] = $urandom_range(0, 255);
      end
      do_reset();
      chk("rst_valid", 32'(resp_valid), 0);
      chk("rst_ready", 32'(req_ready), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_ops", 32'(ops_count), 0);
      a_m[0] = 'h12; b_m[0] = 'h34;
      do_op(4'b0001, 0);
      a_m[1] = 'hF0; b_m[1] = 'h20;
      do_op(4'b0010, 0);
      req_valid = '0;
      #1;
      chk("idle_no_req", 32'(req_ready), 0);
      cyc();
      chk("idle_stay", 32'(busy), 0);
      do_reset();
      for (int n = 0; n < 5; n++) do_op(4'b1111, 0);
      do_op(4'b1111, 5);
      do_op(4'b1111, 0);
      for (int n = 0; n < 25; n++) do_op(4'($urandom_range(1, 15)), $urandom_range(0, 3));
      req_valid = 4'b0100;
      #1;
      chk("mid_grant", 32'(req_ready), 32'(1 << winner(4'b0100, last_g)));
      cyc();
      chk("mid_exec", 32'(busy), 1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(resp_valid), 0);
      chk("mid_rst_busy", 32'(busy), 0);
      repeat (2) begin
         cyc();
         chk("mid_rst_quiet", 32'(resp_valid), 0);
      end
      req_valid = 4'b1010;
      rst_n = 1'b1;
      last_g = 3;
      ops_m = 0;
      #1;
      chk("mid_rst_ops", 32'(ops_count), 0);
      do_op(4'b1010, 0);
      chk("mid_first_id", 32'(last_g), 1);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
